cs147_ctrl_unit: RTL and testbench

Multi-cycle control unit that sequences the 32-bit cs147sec05 DATA_PATH. It decodes the fetched instruction and ZERO, then drives the 32-bit CTRL word through a fixed RESET → FETCH → DECODE → EXEC → MEM → WB loop. It is instantiated beside DATA_PATH and memory in the processor top; one instruction retires every 5 cycles.

---
 rtl/cs147_ctrl_pkg.sv | 143 ++++++++++++++
 rtl/cs147_ctrl_decode.sv | 125 ++++++++++++
 rtl/cs147_ctrl_unit.sv | 71 +++++++
 tb/tb_cs147_ctrl_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/cs147_ctrl_pkg.sv
// Shared encodings for the cs147 multi-cycle control unit: states, opcodes, ALU codes, CTRL bit map.
package cs147_ctrl_pkg;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        C_RARITH, C_SHIFT, C_JR, C_IARITH, C_LUI, C_BEQ, C_BNE,
        C_LW, C_SW, C_JMP, C_JAL, C_PUSH, C_POP, C_ILL
    } iclass_e;

    typedef logic [4:0] alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_MULI  = 6'h1D;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_JMP   = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_PUSH  = 6'h1B;
    localparam logic [5:0] OP_POP   = 6'h1C;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_MUL = 6'h2C;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;
    localparam logic [5:0] F_SLL = 6'h01;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_JR  = 6'h08;

    localparam alu_op_t ALU_NONE = 5'd0;
    localparam alu_op_t ALU_ADD  = 5'd1;
    localparam alu_op_t ALU_SUB  = 5'd2;
    localparam alu_op_t ALU_MUL  = 5'd3;
    localparam alu_op_t ALU_SHR  = 5'd4;
    localparam alu_op_t ALU_SHL  = 5'd5;
    localparam alu_op_t ALU_AND  = 5'd6;
    localparam alu_op_t ALU_OR   = 5'd7;
    localparam alu_op_t ALU_NOR  = 5'd8;
    localparam alu_op_t ALU_SLT  = 5'd9;

    localparam int B_PC_LOAD   = 0;
    localparam int B_PC_SEL_1  = 1;
    localparam int B_PC_SEL_2  = 2;
    localparam int B_PC_SEL_3  = 3;
    localparam int B_MEM_R     = 4;
    localparam int B_MEM_W     = 5;
    localparam int B_R1_SEL_1  = 6;
    localparam int B_REG_R     = 7;
    localparam int B_REG_W     = 8;
    localparam int B_WA_SEL_1  = 9;
    localparam int B_WA_SEL_2  = 10;
    localparam int B_WA_SEL_3  = 11;
    localparam int B_WD_SEL_1  = 12;
    localparam int B_WD_SEL_2  = 13;
    localparam int B_WD_SEL_3  = 14;
    localparam int B_SP_LOAD   = 15;
    localparam int B_OP1_SEL_1 = 16;
    localparam int B_OP2_SEL_1 = 17;
    localparam int B_OP2_SEL_2 = 18;
    localparam int B_OP2_SEL_3 = 19;
    localparam int B_OP2_SEL_4 = 20;
    localparam int B_ALU_LSB   = 21;
    localparam int B_MA_SEL_1  = 26;
    localparam int B_R2_LOAD   = 27;
    localparam int B_DMEM_W    = 28;
    localparam int B_MD_SEL_1  = 29;
    localparam int B_R1_LOAD   = 30;
    localparam int B_MA_SEL_2  = 31;

    function automatic iclass_e decode_class(input logic [5:0] opcode, input logic [5:0] funct);
        iclass_e c;
        c = C_ILL;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_SUB, F_MUL, F_AND, F_OR, F_NOR, F_SLT: c = C_RARITH;
                    F_SLL, F_SRL: c = C_SHIFT;
                    F_JR:         c = C_JR;
                    default:      c = C_ILL;
                endcase
            end
            OP_ADDI, OP_MULI, OP_ANDI, OP_ORI, OP_SLTI: c = C_IARITH;
            OP_LUI:  c = C_LUI;
            OP_BEQ:  c = C_BEQ;
            OP_BNE:  c = C_BNE;
            OP_LW:   c = C_LW;
            OP_SW:   c = C_SW;
            OP_JMP:  c = C_JMP;
            OP_JAL:  c = C_JAL;
            OP_PUSH: c = C_PUSH;
            OP_POP:  c = C_POP;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic alu_op_t alu_code(input logic [5:0] opcode, input logic [5:0] funct);
        alu_op_t a;
        a = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    F_ADD:   a = ALU_ADD;
                    F_SUB:   a = ALU_SUB;
                    F_MUL:   a = ALU_MUL;
                    F_AND:   a = ALU_AND;
                    F_OR:    a = ALU_OR;
                    F_NOR:   a = ALU_NOR;
                    F_SLT:   a = ALU_SLT;
                    F_SLL:   a = ALU_SHL;
                    F_SRL:   a = ALU_SHR;
                    default: a = ALU_NONE;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW, OP_POP: a = ALU_ADD;
            OP_MULI:                       a = ALU_MUL;
            OP_ANDI:                       a = ALU_AND;
            OP_ORI:                        a = ALU_OR;
            OP_SLTI:                       a = ALU_SLT;
            OP_BEQ, OP_BNE, OP_PUSH:       a = ALU_SUB;
            default:                       a = ALU_NONE;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/cs147_ctrl_decode.sv
// Combinational (state, IR, zflag) -> CTRL/ILLEGAL decoder.
// Zero latency; no handshake, the sequencer advances every cycle.
module cs147_ctrl_decode
    import cs147_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 32,
    parameter int ALU_OP_W = 5
) (
    input  state_e              state_i,
    input  logic [31:0]         ir_i,
    input  logic                zflag_i,
    output logic [CTRL_W-1:0]   ctrl_o,
    output logic                illegal_o
);

    logic [5:0] opcode;
    logic [5:0] funct;
    iclass_e    cls;
    logic       unused_ir;

    assign opcode    = ir_i[31:26];
    assign funct     = ir_i[5:0];
    assign cls       = decode_class(opcode, funct);
    assign unused_ir = ^ir_i[25:6];

    always_comb begin
        ctrl_o    = '0;
        illegal_o = 1'b0;

        // ALU selects stay up through MEM/WB so the address and result remain stable.
        if (state_i == S_EXEC || state_i == S_MEM || state_i == S_WB) begin
            ctrl_o[B_ALU_LSB +: ALU_OP_W] = ALU_OP_W'(alu_code(opcode, funct));
            case (cls)
                C_RARITH, C_BEQ, C_BNE: ctrl_o[B_OP2_SEL_4] = 1'b1;
                C_SHIFT: begin
                    ctrl_o[B_OP2_SEL_3] = 1'b1;
                    ctrl_o[B_OP2_SEL_1] = 1'b1;
                end
                C_IARITH, C_LW, C_SW:
                    ctrl_o[B_OP2_SEL_2] = (opcode != OP_ANDI) && (opcode != OP_ORI);
                C_PUSH, C_POP: begin
                    ctrl_o[B_OP1_SEL_1] = 1'b1;
                    ctrl_o[B_OP2_SEL_3] = 1'b1;
                end
                default: ;
            endcase
        end

        case (state_i)
            S_FETCH: begin
                ctrl_o[B_MA_SEL_2] = 1'b1;
                ctrl_o[B_MEM_R]    = 1'b1;
            end
            S_DECODE: begin
                ctrl_o[B_REG_R]    = 1'b1;
                ctrl_o[B_R1_LOAD]  = 1'b1;
                ctrl_o[B_R2_LOAD]  = 1'b1;
                ctrl_o[B_R1_SEL_1] = (cls == C_PUSH);
            end
            S_MEM: begin
                case (cls)
                    C_LW: ctrl_o[B_MEM_R] = 1'b1;
                    C_SW: begin
                        ctrl_o[B_MEM_W]  = 1'b1;
                        ctrl_o[B_DMEM_W] = 1'b1;
                    end
                    C_PUSH: begin
                        ctrl_o[B_MEM_W]    = 1'b1;
                        ctrl_o[B_DMEM_W]   = 1'b1;
                        ctrl_o[B_MA_SEL_1] = 1'b1;
                        ctrl_o[B_MD_SEL_1] = 1'b1;
                    end
                    C_POP: begin
                        ctrl_o[B_MEM_R]    = 1'b1;
                        ctrl_o[B_MA_SEL_1] = 1'b1;
                        ctrl_o[B_SP_LOAD]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_WB: begin
                ctrl_o[B_PC_LOAD]  = 1'b1;
                ctrl_o[B_PC_SEL_1] = 1'b1;
                ctrl_o[B_PC_SEL_3] = 1'b1;
                case (cls)
                    C_RARITH, C_SHIFT: begin
                        ctrl_o[B_REG_W]    = 1'b1;
                        ctrl_o[B_WA_SEL_3] = 1'b1;
                        ctrl_o[B_WD_SEL_3] = 1'b1;
                    end
                    C_IARITH, C_LUI, C_LW: begin
                        ctrl_o[B_REG_W]    = 1'b1;
                        ctrl_o[B_WA_SEL_1] = 1'b1;
                        ctrl_o[B_WA_SEL_3] = 1'b1;
                        ctrl_o[B_WD_SEL_3] = 1'b1;
                        ctrl_o[B_WD_SEL_2] = (cls == C_LUI);
                        ctrl_o[B_WD_SEL_1] = (cls == C_LW);
                    end
                    C_BEQ:  ctrl_o[B_PC_SEL_2] = zflag_i;
                    C_BNE:  ctrl_o[B_PC_SEL_2] = ~zflag_i;
                    C_JR:   ctrl_o[B_PC_SEL_1] = 1'b0;
                    C_JMP:  ctrl_o[B_PC_SEL_3] = 1'b0;
                    C_JAL: begin
                        ctrl_o[B_PC_SEL_3] = 1'b0;
                        ctrl_o[B_REG_W]    = 1'b1;
                        ctrl_o[B_WA_SEL_2] = 1'b1;
                    end
                    C_PUSH: ctrl_o[B_SP_LOAD] = 1'b1;
                    C_POP: begin
                        // SP was incremented at the end of MEM; re-read at the new SP.
                        ctrl_o[B_MEM_R]    = 1'b1;
                        ctrl_o[B_MA_SEL_1] = 1'b1;
                        ctrl_o[B_REG_W]    = 1'b1;
                        ctrl_o[B_WA_SEL_3] = 1'b1;
                        ctrl_o[B_WD_SEL_3] = 1'b1;
                        ctrl_o[B_WD_SEL_1] = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/cs147_ctrl_unit.sv
// Multi-cycle sequencer for the cs147 datapath: RESET->FETCH->DECODE->EXEC->MEM->WB loop.
// CTRL is Moore-decoded from state/IR/zflag; one instruction retires every 5 cycles, no stalls.
module cs147_ctrl_unit
    import cs147_ctrl_pkg::*;
#(
    parameter int CTRL_W   = 32,
    parameter int ALU_OP_W = 5
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       INSTRUCTION,
    input  logic              ZERO,
    output logic [CTRL_W-1:0] CTRL,
    output logic              ILLEGAL
);

    state_e             state_q, state_d;
    logic [31:0]        ir_q, ir_d;
    logic               zflag_q, zflag_d;
    logic [CTRL_W-1:0]  ctrl_dec;
    logic               illegal_dec;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_RESET;
            ir_q    <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            zflag_q <= zflag_d;
        end
    end

    always_comb begin
        state_d = S_RESET;
        ir_d    = ir_q;
        zflag_d = zflag_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_DECODE;
                ir_d    = INSTRUCTION;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                state_d = S_MEM;
                zflag_d = ZERO;
            end
            S_MEM:    state_d = S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_RESET;
        endcase
    end

    cs147_ctrl_decode #(
        .CTRL_W   (CTRL_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decode (
        .state_i   (state_q),
        .ir_i      (ir_q),
        .zflag_i   (zflag_q),
        .ctrl_o    (ctrl_dec),
        .illegal_o (illegal_dec)
    );

    // Reset aborts immediately: no strobe may fire in the cycle RST is sampled low.
    assign CTRL    = RST ? ctrl_dec : '0;
    assign ILLEGAL = RST & illegal_dec;

endmodule

// File: tb/tb_cs147_ctrl_unit.sv
// Directed-vector bench for cs147_ctrl_unit; expected CTRL words are hand-computed from the bit map.
module tb_cs147_ctrl_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] CTRL;
    logic        ILLEGAL;

    int checks = 0;
    int errors = 0;

    logic [31:0] cap_f, cap_d, cap_e, cap_m, cap_w;
    logic        ill_w, ill_o;

    localparam logic [31:0] FETCH_CTRL  = 32'h8000_0010;
    localparam logic [31:0] DECODE_CTRL = 32'h4800_0080;

    always #5 CLK = ~CLK;

    cs147_ctrl_unit #(.CTRL_W(32), .ALU_OP_W(5)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .INSTRUCTION (INSTRUCTION),
        .ZERO        (ZERO),
        .CTRL        (CTRL),
        .ILLEGAL     (ILLEGAL)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Runs one instruction starting in FETCH and ends back in FETCH, capturing CTRL per phase.
    task automatic run_instr(input logic [31:0] ir, input logic z);
        INSTRUCTION = ir;
        ZERO        = 1'b0;
        cap_f = CTRL; ill_o = ILLEGAL;
        step();
        INSTRUCTION = 32'hDEAD_BEEF;
        cap_d = CTRL; ill_o = ill_o | ILLEGAL;
        step();
        ZERO  = z;
        cap_e = CTRL; ill_o = ill_o | ILLEGAL;
        step();
        ZERO  = ~z;
        cap_m = CTRL; ill_o = ill_o | ILLEGAL;
        step();
        cap_w = CTRL; ill_w = ILLEGAL;
        step();
    endtask

    task automatic test_reset();
        RST = 1'b0; INSTRUCTION = 32'h0; ZERO = 1'b0;
        step(); step();
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL reset_hold ctrl=%h exp=%h", CTRL, 32'h0); end
        checks++; if (ILLEGAL !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", ILLEGAL); end
        RST = 1'b1; #1;
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL reset_release ctrl=%h exp=%h", CTRL, 32'h0); end
        step();
        checks++; if (CTRL !== FETCH_CTRL) begin errors++; $display("FAIL reset_fetch ctrl=%h exp=%h", CTRL, FETCH_CTRL); end
    endtask

    task automatic test_rtype();
        run_instr(32'h0109_5020, 1'b0);
        checks++; if (cap_f !== FETCH_CTRL) begin errors++; $display("FAIL add_fetch ctrl=%h exp=%h", cap_f, FETCH_CTRL); end
        checks++; if (cap_d !== DECODE_CTRL) begin errors++; $display("FAIL add_decode ctrl=%h exp=%h", cap_d, DECODE_CTRL); end
        checks++; if (cap_e !== 32'h0030_0000) begin errors++; $display("FAIL add_exec ctrl=%h exp=%h", cap_e, 32'h0030_0000); end
        checks++; if (cap_m !== 32'h0030_0000) begin errors++; $display("FAIL add_mem ctrl=%h exp=%h", cap_m, 32'h0030_0000); end
        checks++; if (cap_w !== 32'h0030_490B) begin errors++; $display("FAIL add_wb ctrl=%h exp=%h", cap_w, 32'h0030_490B); end
        checks++; if ({ill_o, ill_w} !== 2'b00) begin errors++; $display("FAIL add_illegal got=%b exp=00", {ill_o, ill_w}); end
        run_instr(32'h0009_5081, 1'b0);
        checks++; if (cap_e !== 32'h00AA_0000) begin errors++; $display("FAIL sll_exec ctrl=%h exp=%h", cap_e, 32'h00AA_0000); end
        checks++; if (cap_w !== 32'h00AA_490B) begin errors++; $display("FAIL sll_wb ctrl=%h exp=%h", cap_w, 32'h00AA_490B); end
        run_instr(32'h0000_003F, 1'b0);
        checks++; if (cap_w !== 32'h0000_000B) begin errors++; $display("FAIL badfunct_wb ctrl=%h exp=%h", cap_w, 32'h0000_000B); end
        checks++; if ({ill_o, ill_w} !== 2'b01) begin errors++; $display("FAIL badfunct_illegal got=%b exp=01", {ill_o, ill_w}); end
    endtask

    task automatic test_branch();
        run_instr(32'h1109_0004, 1'b1);
        checks++; if (cap_e !== 32'h0050_0000) begin errors++; $display("FAIL beq_exec ctrl=%h exp=%h", cap_e, 32'h0050_0000); end
        checks++; if (cap_w !== 32'h0050_000F) begin errors++; $display("FAIL beq_taken_wb ctrl=%h exp=%h", cap_w, 32'h0050_000F); end
        run_instr(32'h1109_0004, 1'b0);
        checks++; if (cap_w !== 32'h0050_000B) begin errors++; $display("FAIL beq_nottaken_wb ctrl=%h exp=%h", cap_w, 32'h0050_000B); end
        run_instr(32'h1509_0004, 1'b1);
        checks++; if (cap_w !== 32'h0050_000B) begin errors++; $display("FAIL bne_nottaken_wb ctrl=%h exp=%h", cap_w, 32'h0050_000B); end
        run_instr(32'h1509_0004, 1'b0);
        checks++; if (cap_w !== 32'h0050_000F) begin errors++; $display("FAIL bne_taken_wb ctrl=%h exp=%h", cap_w, 32'h0050_000F); end
    endtask

    task automatic test_mem();
        run_instr(32'h8D0A_0010, 1'b0);
        checks++; if (cap_e !== 32'h0024_0000) begin errors++; $display("FAIL lw_exec ctrl=%h exp=%h", cap_e, 32'h0024_0000); end
        checks++; if (cap_m !== 32'h0024_0010) begin errors++; $display("FAIL lw_mem ctrl=%h exp=%h", cap_m, 32'h0024_0010); end
        checks++; if (cap_w !== 32'h0024_5B0B) begin errors++; $display("FAIL lw_wb ctrl=%h exp=%h", cap_w, 32'h0024_5B0B); end
    endtask

    task automatic test_stack();
        run_instr(32'h6C00_0000, 1'b0);
        checks++; if (cap_d !== 32'h4800_00C0) begin errors++; $display("FAIL push_decode ctrl=%h exp=%h", cap_d, 32'h4800_00C0); end
        checks++; if (cap_e !== 32'h0049_0000) begin errors++; $display("FAIL push_exec ctrl=%h exp=%h", cap_e, 32'h0049_0000); end
        checks++; if (cap_m !== 32'h3449_0020) begin errors++; $display("FAIL push_mem ctrl=%h exp=%h", cap_m, 32'h3449_0020); end
        checks++; if (cap_w !== 32'h0049_800B) begin errors++; $display("FAIL push_wb ctrl=%h exp=%h", cap_w, 32'h0049_800B); end
    endtask

    task automatic test_imm_jump();
        run_instr(32'h3109_00FF, 1'b0);
        checks++; if (cap_e !== 32'h00C0_0000) begin errors++; $display("FAIL andi_exec ctrl=%h exp=%h", cap_e, 32'h00C0_0000); end
        checks++; if (cap_w !== 32'h00C0_4B0B) begin errors++; $display("FAIL andi_wb ctrl=%h exp=%h", cap_w, 32'h00C0_4B0B); end
        run_instr(32'h0C00_0010, 1'b0);
        checks++; if (cap_w !== 32'h0000_0503) begin errors++; $display("FAIL jal_wb ctrl=%h exp=%h", cap_w, 32'h0000_0503); end
        run_instr(32'h01E0_0008, 1'b0);
        checks++; if (cap_w !== 32'h0000_0009) begin errors++; $display("FAIL jr_wb ctrl=%h exp=%h", cap_w, 32'h0000_0009); end
    endtask

    task automatic test_illegal();
        run_instr(32'hFC00_0000, 1'b0);
        checks++; if (cap_e !== 32'h0) begin errors++; $display("FAIL ill_exec ctrl=%h exp=%h", cap_e, 32'h0); end
        checks++; if (cap_w !== 32'h0000_000B) begin errors++; $display("FAIL ill_wb ctrl=%h exp=%h", cap_w, 32'h0000_000B); end
        checks++; if ({ill_o, ill_w} !== 2'b01) begin errors++; $display("FAIL ill_pulse got=%b exp=01", {ill_o, ill_w}); end
        checks++; if ({CTRL, ILLEGAL} !== {FETCH_CTRL, 1'b0}) begin errors++; $display("FAIL ill_next ctrl=%h ill=%b exp=%h/0", CTRL, ILLEGAL, FETCH_CTRL); end
    endtask

    task automatic test_reset_mid_exec();
        INSTRUCTION = 32'h0109_5020;
        step(); step();
        checks++; if (CTRL !== 32'h0030_0000) begin errors++; $display("FAIL abort_pre_exec ctrl=%h exp=%h", CTRL, 32'h0030_0000); end
        RST = 1'b0; #1;
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL abort_same_cycle ctrl=%h exp=%h", CTRL, 32'h0); end
        step();
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL abort_hold1 ctrl=%h exp=%h", CTRL, 32'h0); end
        step(); step();
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL abort_hold3 ctrl=%h exp=%h", CTRL, 32'h0); end
        RST = 1'b1; #1;
        checks++; if (CTRL !== 32'h0) begin errors++; $display("FAIL abort_release ctrl=%h exp=%h", CTRL, 32'h0); end
        step();
        checks++; if (CTRL !== FETCH_CTRL) begin errors++; $display("FAIL abort_fetch ctrl=%h exp=%h", CTRL, FETCH_CTRL); end
        run_instr(32'h0109_5020, 1'b0);
        checks++; if (cap_w !== 32'h0030_490B) begin errors++; $display("FAIL abort_resume_wb ctrl=%h exp=%h", cap_w, 32'h0030_490B); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish by t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rtype();
        test_branch();
        test_mem();
        test_stack();
        test_imm_jump();
        test_illegal();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
